// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if: byte-wide AXI-stream bundle used on both sides of the
// receive frame FIFO. The master drives data/valid/last/user; the slave
// drives tready.
interface eth_rx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        input  tready,
        output tlast,
        output tuser
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast,
        input  tuser
    );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward receive frame FIFO behind the RGMII MAC.
// A frame becomes visible to the reader only once its last byte is stored.
// Frames that do not fit are dropped. The output side is a registered-read RAM
// followed by a one-entry output register.
// Optional feature macro: ETH_RX_FIFO_DROP_BAD_EN. When it is defined, frames
// that end with s_axis.tuser=1 are rolled back and m_axis.tuser is always 0.
module eth_rx_frame_fifo #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    eth_rx_frame_fifo_if.slave         s_axis,
    eth_rx_frame_fifo_if.master        m_axis,
    output logic                       status_overflow,
    output logic                       status_bad_frame,
    output logic                       status_good_frame
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef ETH_RX_FIFO_DROP_BAD_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_DROP
    } wr_state_t;

    wr_state_t           wr_state_q, wr_state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] wr_ptr_commit_q, wr_ptr_commit_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                bad_q, bad_d;
    logic                good_q, good_d;
    logic                ram_valid_q, ram_valid_d;
    logic                out_valid_q, out_valid_d;
    logic [9:0]          out_word_q, out_word_d;

    logic [9:0]          mem [2**ADDR_WIDTH];
    logic [9:0]          ram_rdata;
    logic [9:0]          wr_word;
    logic                wr_user;
    logic                wr_en;
    logic                rd_en;
    logic                full;
    logic                empty;
    logic                out_load;

    // The MAC cannot be back-pressured, so the input always accepts.
    assign s_axis.tready = 1'b1;

    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_PTR;
    assign empty    = (rd_ptr_q == wr_ptr_commit_q);
`ifdef ETH_RX_FIFO_DROP_BAD_EN
    assign wr_user  = 1'b0;
`else
    assign wr_user  = s_axis.tuser & s_axis.tlast;
`endif
    assign wr_word  = {wr_user, s_axis.tlast, s_axis.tdata};

    // Write-side FSM: store beats speculatively, commit or roll back on tlast.
    always_comb begin
        wr_state_d      = wr_state_q;
        wr_ptr_d        = wr_ptr_q;
        wr_ptr_commit_d = wr_ptr_commit_q;
        overflow_d      = 1'b0;
        bad_d           = 1'b0;
        good_d          = 1'b0;
        wr_en           = 1'b0;
        if (s_axis.tvalid) begin
            case (wr_state_q)
                WR_DROP: begin
                    if (s_axis.tlast) begin
                        wr_ptr_d   = wr_ptr_commit_q;
                        overflow_d = 1'b1;
                        wr_state_d = WR_IDLE;
                    end
                end
                default: begin
                    if (full) begin
                        if (s_axis.tlast) begin
                            wr_ptr_d   = wr_ptr_commit_q;
                            overflow_d = 1'b1;
                            wr_state_d = WR_IDLE;
                        end else begin
                            wr_state_d = WR_DROP;
                        end
                    end else if (s_axis.tlast) begin
                        if (s_axis.tuser && DROP_BAD) begin
                            wr_ptr_d   = wr_ptr_commit_q;
                            bad_d      = 1'b1;
                        end else begin
                            wr_en           = 1'b1;
                            wr_ptr_d        = wr_ptr_q + PTR_ONE;
                            wr_ptr_commit_d = wr_ptr_q + PTR_ONE;
                            bad_d           = s_axis.tuser;
                            good_d          = ~s_axis.tuser;
                        end
                        wr_state_d = WR_IDLE;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        wr_state_d = WR_ACTIVE;
                    end
                end
            endcase
        end
    end

    // Read side: RAM output stage feeds the output register, both stall together.
    always_comb begin
        out_load    = ~out_valid_q | m_axis.tready;
        rd_en       = ~empty & (~ram_valid_q | out_load);
        rd_ptr_d    = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ram_valid_d = rd_en | (ram_valid_q & ~out_load);
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        if (out_load) begin
            out_valid_d = ram_valid_q;
            if (ram_valid_q) begin
                out_word_d = ram_rdata;
            end
        end
    end

    // Frame buffer: simple dual-port RAM with a registered, enabled read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
        end
        if (rd_en) begin
            ram_rdata <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // State, pointer and output registers; reset discards every stored frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q      <= WR_IDLE;
            wr_ptr_q        <= '0;
            wr_ptr_commit_q <= '0;
            rd_ptr_q        <= '0;
            overflow_q      <= 1'b0;
            bad_q           <= 1'b0;
            good_q          <= 1'b0;
            ram_valid_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_word_q      <= '0;
        end else begin
            wr_state_q      <= wr_state_d;
            wr_ptr_q        <= wr_ptr_d;
            wr_ptr_commit_q <= wr_ptr_commit_d;
            rd_ptr_q        <= rd_ptr_d;
            overflow_q      <= overflow_d;
            bad_q           <= bad_d;
            good_q          <= good_d;
            ram_valid_q     <= ram_valid_d;
            out_valid_q     <= out_valid_d;
            out_word_q      <= out_word_d;
        end
    end

    assign m_axis.tvalid     = out_valid_q;
    assign m_axis.tdata      = out_word_q[7:0];
    assign m_axis.tlast      = out_word_q[8];
    assign m_axis.tuser      = out_word_q[9];
    assign status_overflow   = overflow_q;
    assign status_bad_frame  = bad_q;
    assign status_good_frame = good_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: self-checking bench for the receive frame FIFO.
// The reference model is a queue of expected output words; a frame is added to
// it when its last byte is sent, if it fits in the free space and is forwarded.
module tb_eth_rx_frame_fifo;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
`ifdef ETH_RX_FIFO_DROP_BAD_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic status_overflow;
    logic status_bad_frame;
    logic status_good_frame;

    eth_rx_frame_fifo_if s_if ();
    eth_rx_frame_fifo_if m_if ();

    eth_rx_frame_fifo #(.ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis            (s_if),
        .m_axis            (m_if),
        .status_overflow   (status_overflow),
        .status_bad_frame  (status_bad_frame),
        .status_good_frame (status_good_frame)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [9:0] exp_q[$];
    int         rx_beats   = 0;
    int         rx_lasts   = 0;
    bit         rand_ready = 1'b0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_word  = '0;
    logic [9:0] mon_word;
    logic [9:0] mon_exp;

    // Free-running 100 MHz receive clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; optionally randomise tready.
    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
    endtask

    // Send one frame, update the model, and check the status pulses.
    task automatic applyStimulus(input int len, input bit bad, input bit rnd, input bit gaps);
        logic [7:0] bytes[$];
        logic [7:0] b;
        bit         fits;
        bit         fwd;
        fits = (len <= DEPTH - exp_q.size());
        fwd  = fits && !(bad && DROP_BAD);
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            bytes.push_back(b);
            if (gaps) begin
                while ($urandom_range(0, 9) == 0) begin
                    s_if.tvalid = 1'b0;
                    tick();
                end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = b;
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = bad && (i == len - 1);
            tick();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        if (fwd) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({bad && (i == len - 1), i == len - 1, bytes[i]});
            end
        end
        checkOutput("status_overflow", status_overflow, !fits);
        checkOutput("status_bad", status_bad_frame, fits && bad);
        checkOutput("status_good", status_good_frame, fits && !bad);
        tick();
        checkOutput("status_clear", {status_overflow, status_bad_frame, status_good_frame}, 3'b000);
    endtask

    // Wait (bounded) until every expected byte has been seen at the output.
    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checkOutput("drain_left", exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard accepted beats and check stability under stall.
    always @(negedge clk) begin
        mon_word = {m_if.tuser, m_if.tlast, m_if.tdata};
        if (rst_n !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", m_if.tvalid, 1'b1);
                checkOutput("stall_word", mon_word, prev_word);
            end
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                rx_beats++;
                if (m_if.tlast === 1'b1) rx_lasts++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", m_if.tvalid, 1'b0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("out_beat", mon_word, mon_exp);
                end
            end
            prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
            prev_word  = mon_word;
        end
    end

    // Directed and randomised test sequence.
    initial begin
        int b0;
        int l0;
        int len;
        rst_n       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_tvalid", m_if.tvalid, 1'b0);
        checkOutput("reset_word", {m_if.tuser, m_if.tlast, m_if.tdata}, 10'h000);
        checkOutput("reset_status", {status_overflow, status_bad_frame, status_good_frame}, 3'b000);
        rst_n = 1'b1;
        tick();

        $display("[TB] single 64-byte good frame");
        m_if.tready = 1'b1;
        b0 = rx_beats; l0 = rx_lasts;
        applyStimulus(64, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_e1", m_if.tvalid, 1'b0);
        tick();
        checkOutput("latency_e2", m_if.tvalid, 1'b1);
        waitDrain(200);
        checkOutput("good_beats", rx_beats - b0, 64);
        checkOutput("good_lasts", rx_lasts - l0, 1);

        $display("[TB] 64-byte bad frame");
        b0 = rx_beats;
        applyStimulus(64, 1'b1, 1'b0, 1'b0);
        waitDrain(200);
        checkOutput("bad_beats", rx_beats - b0, DROP_BAD ? 0 : 64);
        b0 = rx_beats;
        applyStimulus(60, 1'b0, 1'b1, 1'b0);
        waitDrain(200);
        checkOutput("after_bad_beats", rx_beats - b0, 60);

        $display("[TB] oversized frame into empty FIFO");
        b0 = rx_beats;
        applyStimulus(5000, 1'b0, 1'b1, 1'b0);
        waitDrain(200);
        checkOutput("oversize_beats", rx_beats - b0, 0);
        applyStimulus(60, 1'b0, 1'b1, 1'b0);
        waitDrain(200);
        checkOutput("after_oversize_beats", rx_beats - b0, 60);

        $display("[TB] frame of exactly the buffer depth, then depth plus one");
        b0 = rx_beats;
        applyStimulus(DEPTH, 1'b0, 1'b1, 1'b0);
        waitDrain(DEPTH + 100);
        checkOutput("depth_beats", rx_beats - b0, DEPTH);
        b0 = rx_beats;
        applyStimulus(DEPTH + 1, 1'b0, 1'b1, 1'b0);
        applyStimulus(64, 1'b0, 1'b1, 1'b0);
        waitDrain(200);
        checkOutput("depth_plus1_beats", rx_beats - b0, 64);

        $display("[TB] three frames with output stalled");
        m_if.tready = 1'b0;
        b0 = rx_beats; l0 = rx_lasts;
        applyStimulus(1500, 1'b0, 1'b1, 1'b0);
        applyStimulus(1500, 1'b0, 1'b1, 1'b0);
        applyStimulus(1500, 1'b0, 1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("stalled_beats", rx_beats - b0, 0);
        m_if.tready = 1'b1;
        waitDrain(3200);
        checkOutput("stalled_drain_beats", rx_beats - b0, 3000);
        checkOutput("stalled_drain_lasts", rx_lasts - l0, 2);

        $display("[TB] random frames with random tready");
        rand_ready = 1'b1;
        b0 = rx_beats; l0 = rx_lasts;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(64, 1518);
            for (int w = 0; w < 20000 && (exp_q.size() + len > DEPTH - 8); w++) tick();
            checkOutput("gate_wait", exp_q.size() + len > DEPTH - 8, 1'b0);
            applyStimulus(len, 1'b0, 1'b1, 1'b1);
        end
        waitDrain(40000);
        checkOutput("random_lasts", rx_lasts - l0, 12);
        rand_ready  = 1'b0;
        m_if.tready = 1'b1;
        tick();

        $display("[TB] reset while a frame is being output");
        applyStimulus(1500, 1'b0, 1'b1, 1'b0);
        repeat (100) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_tvalid", m_if.tvalid, 1'b0);
        checkOutput("rst_mid_word", {m_if.tuser, m_if.tlast, m_if.tdata}, 10'h000);
        checkOutput("rst_mid_status", {status_overflow, status_bad_frame, status_good_frame}, 3'b000);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rst_after_tvalid", m_if.tvalid, 1'b0);
        b0 = rx_beats; l0 = rx_lasts;
        applyStimulus(64, 1'b0, 1'b0, 1'b0);
        waitDrain(200);
        checkOutput("post_reset_beats", rx_beats - b0, 64);
        checkOutput("post_reset_lasts", rx_lasts - l0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
